// File: rtl/relm_div_sequencer.sv
// Multi-cycle divide controller: owns the ReLM custom unit, issues DIV/DIVINIT/DIVLOOP/DIVMOD
// and loops the unit's A/CB results back through its own registers.
module relm_div_sequencer #(
  parameter int WD  = 32,
  parameter int WOP = 5,
  parameter int WC  = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WD-1:0]    req_n,
  input  logic [WD-1:0]    req_d,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WD-1:0]    rsp_q,
  output logic [WD-1:0]    rsp_r,
  output logic             rsp_dz,
  output logic             cu_own,
  output logic [WOP-1:0]   cu_op,
  output logic             cu_opb,
  output logic [WD-1:0]    cu_x,
  output logic [WD-1:0]    cu_a,
  output logic [WD-1:0]    cu_xb,
  output logic [WC+WD-1:0] cu_cb,
  input  logic [WD-1:0]    cu_a_in,
  input  logic [WC+WD-1:0] cu_cb_in
);

  localparam int WCB = WC + WD;
  localparam int LW  = $clog2(WD);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_DIV  = 3'd1;
  localparam logic [2:0] S_CALC = 3'd2;
  localparam logic [2:0] S_INIT = 3'd3;
  localparam logic [2:0] S_LOOP = 3'd4;
  localparam logic [2:0] S_MOD  = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  localparam logic [1:0] OP_DIV     = 2'b00;
  localparam logic [1:0] OP_DIVINIT = 2'b01;
  localparam logic [1:0] OP_DIVLOOP = 2'b10;
  localparam logic [1:0] OP_DIVMOD  = 2'b11;

  logic [2:0]     state;
  logic [WD-1:0]  a_q;
  logic [WCB-1:0] cb_q;
  logic [WD-1:0]  n_q;
  logic [WD-1:0]  d_q;
  logic [WD-1:0]  q_q;
  logic [WD-1:0]  r_q;
  logic           dz_q;
  logic [WD-1:0]  q0_q;

  // Position of the highest set bit; A and CB.b hold one-hot values in CALC.
  function automatic logic [LW-1:0] msb_pos(input logic [WD-1:0] v);
    msb_pos = '0;
    for (int i = 0; i < WD; i++) begin
      if (v[i]) msb_pos = LW'(i);
    end
  endfunction

  logic [LW-1:0] log_n;
  logic [LW-1:0] log_d;
  logic          q_zero;
  logic [WD-1:0] q0_next;

  always_comb begin
    log_n   = msb_pos(a_q);
    log_d   = msb_pos(cb_q[WD-1:0]);
    q_zero  = (a_q == '0) || (log_n < log_d);
    q0_next = {{(WD-1){1'b0}}, 1'b1} << (log_n - log_d);
  end

  // CALC keeps ownership but issues no sub-op, so x/a/xb/cb stay zero there.
  logic [1:0] sub_op;
  logic       issue;

  always_comb begin
    cu_own = 1'b0;
    issue  = 1'b0;
    sub_op = OP_DIV;
    cu_a   = '0;
    cu_xb  = '0;
    cu_cb  = '0;
    case (state)
      S_DIV: begin
        cu_own = 1'b1;
        issue  = 1'b1;
        sub_op = OP_DIV;
        cu_a   = n_q;
        cu_xb  = d_q;
      end
      S_CALC: cu_own = 1'b1;
      S_INIT: begin
        cu_own = 1'b1;
        issue  = 1'b1;
        sub_op = OP_DIVINIT;
        cu_a   = q0_q;
        cu_cb  = cb_q;
      end
      S_LOOP: begin
        cu_own = 1'b1;
        issue  = 1'b1;
        sub_op = OP_DIVLOOP;
        cu_a   = a_q;
        cu_cb  = cb_q;
      end
      S_MOD: begin
        cu_own = 1'b1;
        issue  = 1'b1;
        sub_op = OP_DIVMOD;
        cu_a   = a_q;
        cu_cb  = cb_q;
      end
      default: ;
    endcase
    cu_opb = cu_own;
    cu_op  = cu_own ? WOP'(3'b101) : '0;
    cu_x   = issue ? (WD'(sub_op) << WOP) : '0;
  end

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_DONE);
  assign rsp_q     = q_q;
  assign rsp_r     = r_q;
  assign rsp_dz    = dz_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      a_q   <= '0;
      cb_q  <= '0;
      n_q   <= '0;
      d_q   <= '0;
      q_q   <= '0;
      r_q   <= '0;
      dz_q  <= 1'b0;
      q0_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            n_q <= req_n;
            d_q <= req_d;
            if (req_d == '0) begin
              q_q   <= '1;
              r_q   <= req_n;
              dz_q  <= 1'b1;
              state <= S_DONE;
            end else begin
              state <= S_DIV;
            end
          end
        end
        S_DIV: begin
          a_q   <= cu_a_in;
          cb_q  <= cu_cb_in;
          state <= S_CALC;
        end
        S_CALC: begin
          if (q_zero) begin
            q_q   <= '0;
            r_q   <= n_q;
            dz_q  <= 1'b0;
            state <= S_DONE;
          end else begin
            q0_q  <= q0_next;
            state <= S_INIT;
          end
        end
        S_INIT: begin
          a_q   <= cu_a_in;
          cb_q  <= cu_cb_in;
          state <= S_LOOP;
        end
        S_LOOP: begin
          a_q  <= cu_a_in;
          cb_q <= cu_cb_in;
          if (cu_a_in == '0) state <= S_MOD;
        end
        S_MOD: begin
          a_q   <= cu_a_in;
          cb_q  <= cu_cb_in;
          q_q   <= cu_cb_in[WD-1:0];
          r_q   <= cu_a_in;
          dz_q  <= 1'b0;
          state <= S_DONE;
        end
        S_DONE: begin
          if (rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_relm_div_sequencer.sv
// Directed bench for relm_div_sequencer with a behavioural model of the custom unit's
// divide sub-ops (restoring division, two quotient bits per DIVLOOP).
module tb_relm_div_sequencer;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_n;
  logic [31:0] req_d;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_q;
  logic [31:0] rsp_r;
  logic        rsp_dz;
  logic        cu_own;
  logic [4:0]  cu_op;
  logic        cu_opb;
  logic [31:0] cu_x;
  logic [31:0] cu_a;
  logic [31:0] cu_xb;
  logic [95:0] cu_cb;
  logic [31:0] cu_a_in;
  logic [95:0] cu_cb_in;

  int n_pass;
  int n_total;

  relm_div_sequencer dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_n(req_n), .req_d(req_d),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_q(rsp_q), .rsp_r(rsp_r), .rsp_dz(rsp_dz),
    .cu_own(cu_own), .cu_op(cu_op), .cu_opb(cu_opb), .cu_x(cu_x),
    .cu_a(cu_a), .cu_xb(cu_xb), .cu_cb(cu_cb),
    .cu_a_in(cu_a_in), .cu_cb_in(cu_cb_in)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // custom unit model: CB = {top(rem/N), mid(c/D), low(b/d)}
  function automatic logic [31:0] onehot_msb(input logic [31:0] v);
    onehot_msb = '0;
    for (int i = 0; i < 32; i++) if (v[i]) onehot_msb = 32'd1 << i;
  endfunction

  logic [31:0] m_rem, m_c, m_b, m_m;
  always_comb begin
    cu_a_in  = '0;
    cu_cb_in = '0;
    m_rem    = cu_cb[95:64];
    m_c      = cu_cb[63:32];
    m_b      = cu_cb[31:0];
    m_m      = cu_a;
    if (cu_own && cu_opb) begin
      case (cu_x[6:5])
        2'b00: begin
          cu_a_in  = onehot_msb(cu_a);
          cu_cb_in = {cu_a, cu_xb, onehot_msb(cu_xb)};
        end
        2'b01: begin
          cu_a_in  = cu_a;
          cu_cb_in = {m_rem, m_c * cu_a, 32'd0};
        end
        2'b10: begin
          for (int s = 0; s < 2; s++) begin
            if (m_m != 0) begin
              if (m_rem >= m_c) begin
                m_rem = m_rem - m_c;
                m_b   = m_b | m_m;
              end
              m_c = m_c >> 1;
              m_m = m_m >> 1;
            end
          end
          cu_a_in  = m_m;
          cu_cb_in = {m_rem, m_c, m_b};
        end
        default: begin
          cu_a_in  = m_rem;
          cu_cb_in = cu_cb;
        end
      endcase
    end
  end

  function automatic logic cu_quiet();
    return (cu_op == 0) && !cu_opb && (cu_x == 0) && (cu_a == 0) && (cu_xb == 0) && (cu_cb == 0);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // driver: issue one divide, follow it to the response and retire it
  task automatic run_div(input logic [31:0] n, input logic [31:0] d,
                         input logic [31:0] eq, input logic [31:0] er, input logic edz,
                         input int ecyc, input int eown, input int eloop, input int einit,
                         input int hold);
    int k, own_cnt, loop_cnt, init_cnt, quiet_bad, op_bad;
    logic [31:0] hq, hr;
    @(negedge clk);
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_n     = n;
    req_d     = d;
    rsp_ready = (hold == 0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_n     = $urandom;
    req_d     = $urandom;
    k = 0; own_cnt = 0; loop_cnt = 0; init_cnt = 0; quiet_bad = 0; op_bad = 0;
    while (1) begin
      @(negedge clk);
      k++;
      if (cu_own) begin
        own_cnt++;
        if (cu_op != 5'b00101 || !cu_opb) op_bad++;
        if (cu_x[6:5] == 2'b10) loop_cnt++;
        if (cu_x[6:5] == 2'b01) init_cnt++;
      end else if (!cu_quiet()) begin
        quiet_bad++;
      end
      if (rsp_valid || k >= 60) break;
    end
    check("rsp_cycle", k, ecyc);
    check("rsp_q", rsp_q, eq);
    check("rsp_r", rsp_r, er);
    check("rsp_dz", rsp_dz, edz);
    check("own_cycles", own_cnt, eown);
    check("loop_issues", loop_cnt, eloop);
    check("init_issues", init_cnt, einit);
    check("own_op_fields", op_bad, 0);
    check("cu_quiet_unowned", quiet_bad, 0);
    check("req_ready_busy", req_ready, 0);
    hq = eq;
    hr = er;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", rsp_valid, 1);
      check("hold_q", rsp_q, hq);
      check("hold_r", rsp_r, hr);
      check("hold_req_ready", req_ready, 0);
    end
    if (hold > 0) rsp_ready = 1'b1;
    @(negedge clk);
    check("post_rsp_valid", rsp_valid, 0);
    check("post_req_ready", req_ready, 1);
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_n     = '0;
    req_d     = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_q", rsp_q, 0);
    check("rst_rsp_r", rsp_r, 0);
    check("rst_rsp_dz", rsp_dz, 0);
    check("rst_cu_own", cu_own, 0);
    check("rst_cu_quiet", cu_quiet(), 1);
    rst = 1'b0;

    // n, d, q, r, dz, rsp cycle, own cycles, DIVLOOPs, DIVINITs, backpressure cycles
    run_div(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 8, 7, 3, 1, 0);
    run_div(32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 3, 2, 0, 0, 0);
    run_div(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 21, 20, 16, 1, 0);
    run_div(32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 1'b1, 1, 0, 0, 0, 0);
    run_div(32'd7, 32'd7, 32'd1, 32'd0, 1'b0, 6, 5, 1, 1, 0);
    run_div(32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 3, 2, 0, 0, 0);
    run_div(32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 10, 9, 5, 1, 10);

    // reset in the middle of DIVLOOP abandons the divide
    @(negedge clk);
    req_valid = 1'b1;
    req_n     = 32'h8000_0000;
    req_d     = 32'd3;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("mid_loop_own", cu_own, 1);
    check("mid_loop_x", cu_x[6:5], 2'b10);
    rst = 1'b1;
    @(negedge clk);
    check("abort_req_ready", req_ready, 1);
    check("abort_cu_own", cu_own, 0);
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_cu_quiet", cu_quiet(), 1);
    rst = 1'b0;
    run_div(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 7, 6, 2, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
